// File: rtl/cram_pkg.sv
// CRAM loader shared definitions: FSM states and CRC-16 constants.
// The CRC step is shared by both checksum engines and the verify compare.
package cram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DONE
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] c,
        input logic        b
    );
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cram_crc16.sv
// Bit-serial CRC-16 register (MSB-first, no reflection, no final XOR).
// clr_i reloads the init value; en_i folds in one bit.
module cram_crc16
    import cram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    assign crc_d = crc16_step(crc_q, bit_i);
    assign crc_o = crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/cram_loader.sv
// CRAM configuration loader: streams a bitstream into the config chain,
// then recirculates the chain once to CRC-check what it holds.
module cram_loader
    import cram_pkg::*;
#(
    parameter int CHAIN_LEN  = 1024,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  cfg_data,
    output logic                  cfg_en,
    input  logic                  cfg_return,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           crc
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int HW = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [WORD_WIDTH-1:0] buf_q;
    logic [HW-1:0]         held_q;
    logic                  done_q;
    logic                  pass_q;

    logic          in_load;
    logic          in_verify;
    logic          shift_load;
    logic          last_bit;
    logic          go;
    logic          accept;
    logic [CW-1:0] need;
    logic [15:0]   ld_crc;
    logic [15:0]   vf_crc;
    logic [15:0]   vf_crc_d;

    assign in_load    = (state_q == ST_LOAD);
    assign in_verify  = (state_q == ST_VERIFY);
    assign shift_load = in_load && (held_q != '0);
    assign last_bit   = (cnt_q == LAST);
    assign go         = (state_q == ST_IDLE) && start && !abort;
    assign need       = CW'(CHAIN_LEN) - cnt_q;

    // Refill only when the buffer is empty or draining its last bit now,
    // and only if the chain still wants more than what is buffered.
    assign s_ready = in_load
                  && (int'(need) > int'(held_q))
                  && (held_q <= HW'(1));
    assign accept  = s_valid && s_ready;

    assign cfg_en   = shift_load || in_verify;
    assign cfg_data = in_verify ? cfg_return : buf_q[WORD_WIDTH-1];
    assign busy     = in_load || in_verify;
    assign done     = done_q;
    assign pass     = pass_q;
    assign crc      = ld_crc;

    assign vf_crc_d = crc16_step(vf_crc, cfg_return);

    cram_crc16 u_ld_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (go),
        .en_i  (shift_load),
        .bit_i (cfg_data),
        .crc_o (ld_crc)
    );

    cram_crc16 u_vf_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (go),
        .en_i  (in_verify),
        .bit_i (cfg_return),
        .crc_o (vf_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            held_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (abort && busy) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            held_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        buf_q   <= '0;
                        held_q  <= '0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (shift_load) begin
                        if (last_bit) begin
                            // Leftover low bits of the final word are dropped.
                            state_q <= ST_VERIFY;
                            cnt_q   <= '0;
                            buf_q   <= '0;
                            held_q  <= '0;
                        end else begin
                            cnt_q  <= cnt_q + CW'(1);
                            buf_q  <= buf_q << 1;
                            held_q <= held_q - HW'(1);
                        end
                    end
                    if (accept) begin
                        buf_q  <= s_data;
                        held_q <= HW'(WORD_WIDTH);
                    end
                end
                ST_VERIFY: begin
                    if (last_bit) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        pass_q  <= (vf_crc_d == ld_crc);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader: 20-bit chain plus a 1-bit chain,
// with a chain model, a bit scoreboard and a result scoreboard.
module tb_cram_loader;

    localparam int L  = 20;
    localparam int WW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          abort;
    logic [WW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          cfg_data;
    logic          cfg_en;
    logic          cfg_return;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   crc;
    logic          flip;
    logic [L-1:0]  chain_q = '0;

    logic          start1;
    logic          abort1;
    logic [WW-1:0] s_data1;
    logic          s_valid1;
    logic          s_ready1;
    logic          cfg_data1;
    logic          cfg_en1;
    logic          cfg_return1;
    logic          busy1;
    logic          done1;
    logic          pass1;
    logic [15:0]   crc1;
    logic          chain1_q = 1'b0;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [WW-1:0] words [3] = '{8'hA5, 8'h3C, 8'hF0};
    logic [L-1:0]  exp_chain = 20'hA53CF;

    typedef struct packed {
        logic [15:0] crc;
        logic        pass;
    } res_t;

    bit   exp_bits [$];
    res_t exp_res  [$];

    cram_loader #(.CHAIN_LEN(L), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .cfg_data   (cfg_data),
        .cfg_en     (cfg_en),
        .cfg_return (cfg_return),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .crc        (crc)
    );

    cram_loader #(.CHAIN_LEN(1), .WORD_WIDTH(WW)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .abort      (abort1),
        .s_data     (s_data1),
        .s_valid    (s_valid1),
        .s_ready    (s_ready1),
        .cfg_data   (cfg_data1),
        .cfg_en     (cfg_en1),
        .cfg_return (cfg_return1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .crc        (crc1)
    );

    always @(posedge clk) if (cfg_en) chain_q <= {chain_q[L-2:0], cfg_data};
    always @(posedge clk) if (cfg_en1) chain1_q <= cfg_data1;
    assign cfg_return  = chain_q[L-1] ^ flip;
    assign cfg_return1 = chain1_q;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [L-1:0] v, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic chk_reset(input string t);
        check({t, "_rdy"},  s_ready,  0);
        check({t, "_en"},   cfg_en,   0);
        check({t, "_dat"},  cfg_data, 0);
        check({t, "_busy"}, busy,     0);
        check({t, "_done"}, done,     0);
        check({t, "_pass"}, pass,     0);
        check({t, "_crc"},  crc,      16'hFFFF);
    endtask

    task automatic run(input int gap, input int abort_bit, input int flip_at,
                       input int poke_at, input int rst_at);
        int   wi = 0;
        int   gapc = 0;
        int   shifts = 0;
        int   lows = 0;
        int   hs = 0;
        int   cyc = 0;
        int   dc;
        bit   aborted = 0;
        res_t r;
        exp_bits.delete();
        dc = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        if (abort_bit < 0 && rst_at < 0) begin
            r.crc  = crc_ref(exp_chain, L);
            r.pass = (flip_at < 0);
            exp_res.push_back(r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        while (shifts < L && cyc < 200 && !aborted) begin
            s_valid = (wi < 3) && !(wi == 1 && gapc < gap);
            s_data  = words[wi < 3 ? wi : 2];
            abort   = (shifts == abort_bit);
            @(negedge clk);
            check("ld_busy", busy, 1);
            if (cfg_en) begin
                if (exp_bits.size() == 0) check("ld_extra", cfg_en, 0);
                else check("ld_bit", cfg_data, exp_bits.pop_front());
                shifts++;
            end else if (shifts > 0) begin
                lows++;
            end
            if (s_valid && s_ready) begin
                for (int b = WW - 1; b >= 0; b--) exp_bits.push_back(words[wi][b]);
                wi++;
                hs++;
            end else if (wi == 1 && s_ready && !s_valid) begin
                gapc++;
            end
            if (abort) aborted = 1;
            @(posedge clk); #1;
            abort = 1'b0;
            cyc++;
        end
        s_valid = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check("ab_busy", busy,    0);
            check("ab_en",   cfg_en,  0);
            check("ab_rdy",  s_ready, 0);
            check("ab_done", done,    0);
            check("ab_pass", pass,    0);
            repeat (25) @(negedge clk);
            check("ab_nodone", done_cnt - dc, 0);
            return;
        end
        check("ld_shifts", shifts, L);
        check("ld_hs",     hs, 3);
        check("ld_gap",    lows, gap);
        check("ld_drop",   exp_bits.size(), 3 * WW - L);
        check("ld_chain",  chain_q, exp_chain);
        for (int v = 0; v < L; v++) begin
            flip  = (v == flip_at);
            start = (v == poke_at);
            rst   = (v == rst_at);
            @(negedge clk);
            check("vf_en",   cfg_en, 1);
            check("vf_loop", cfg_data, cfg_return);
            if (rst) begin
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                flip = 1'b0;
                @(negedge clk);
                chk_reset("rv");
                return;
            end
            @(posedge clk); #1;
        end
        flip  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        r = exp_res.pop_front();
        check("dn_done", done, 1);
        check("dn_pass", pass, r.pass);
        check("dn_crc",  crc,  r.crc);
        if (flip_at < 0) check("dn_chain", chain_q, exp_chain);
        @(negedge clk);
        check("dn_pulse", done, 0);
        check("dn_idle",  busy, 0);
        check("dn_hold",  pass, r.pass);
        repeat (25) @(negedge clk);
        check("dn_once", done_cnt - dc, 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        flip = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        s_valid1 = 1'b0;
        s_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        check("rst1_busy", busy1, 0);
        check("rst1_crc",  crc1,  16'hFFFF);
        @(posedge clk); #1;
        rst = 1'b0;

        run(0, -1, -1, -1, -1);
        run(5, -1, -1, -1, -1);
        run(0, -1, 7, -1, -1);
        run(0, 10, -1, -1, -1);
        run(0, -1, -1, -1, -1);
        run(0, -1, -1, 5, -1);
        run(0, -1, -1, -1, 5);
        run(0, -1, -1, -1, -1);

        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("as_idle", busy, 0);

        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        s_valid1 = 1'b1;
        s_data1 = 8'h80;
        @(negedge clk);
        check("c1_rdy", s_ready1, 1);
        check("c1_en0", cfg_en1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("c1_en",   cfg_en1,   1);
        check("c1_bit",  cfg_data1, 1);
        check("c1_rdy0", s_ready1,  0);
        @(posedge clk); #1;
        s_valid1 = 1'b0;
        @(negedge clk);
        check("c1_ven",  cfg_en1,   1);
        check("c1_vbit", cfg_data1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("c1_done", done1, 1);
        check("c1_pass", pass1, 1);
        check("c1_crc",  crc1,  crc_ref(20'h1, 1));
        @(negedge clk);
        check("c1_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
